// File: rtl/imem_boot_loader.sv
// Boot sequencer: accepts 32-bit instruction words and writes them as four
// little-endian byte writes, then releases the core after a settle delay.
module imem_boot_loader #(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned RELEASE_DELAY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [7:0]        im_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-2:0] word_count
);

  localparam logic [2:0] LOAD   = 3'd0;
  localparam logic [2:0] W0     = 3'd1;
  localparam logic [2:0] W1     = 3'd2;
  localparam logic [2:0] W2     = 3'd3;
  localparam logic [2:0] W3     = 3'd4;
  localparam logic [2:0] SETTLE = 3'd5;
  localparam logic [2:0] RUN    = 3'd6;
  localparam logic [2:0] ERROR  = 3'd7;

  // Usable word slots above BASE_ADDR; the overflow check never lets writes wrap.
  localparam int unsigned       CAP        = ((1 << ADDR_W) - BASE_ADDR) / 4;
  localparam logic [ADDR_W-2:0] LAST_SLOT  = (ADDR_W-1)'(CAP - 1);
  localparam logic [3:0]        SETTLE_END = 4'(RELEASE_DELAY - 1);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

  logic [2:0]        state, nxt;
  logic [31:0]       word_q;
  logic              last_q;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] wbase;

  always_comb begin
    wbase = BASE + {word_count[ADDR_W-3:0], 2'b00};
  end

  always_comb begin
    nxt = state;
    case (state)
      LOAD:    if (ld_valid && ld_ready) nxt = W0;
      W0:      nxt = W1;
      W1:      nxt = W2;
      W2:      nxt = W3;
      W3: begin
        if (last_q)                       nxt = SETTLE;
        else if (word_count == LAST_SLOT) nxt = ERROR;
        else                              nxt = LOAD;
      end
      SETTLE:  if (cnt == SETTLE_END) nxt = RUN;
      RUN:     nxt = RUN;
      ERROR:   nxt = ERROR;
      default: nxt = LOAD;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      ld_ready   <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      cnt        <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      state      <= nxt;
      ld_ready   <= (nxt == LOAD);
      im_we      <= (nxt == W0) || (nxt == W1) || (nxt == W2) || (nxt == W3);
      core_reset <= (nxt != RUN);
      done       <= (nxt == RUN);
      err        <= (nxt == ERROR);
      cnt        <= (state == SETTLE) ? cnt + 4'd1 : '0;
      if (state == LOAD && nxt == W0) begin
        word_q <= ld_data;
        last_q <= ld_last;
      end
      if (state == W3) word_count <= word_count + (ADDR_W-1)'(1);
      case (nxt)
        W0: begin
          im_addr  <= wbase;
          im_wdata <= ld_data[7:0];
        end
        W1: begin
          im_addr  <= wbase + ADDR_W'(1);
          im_wdata <= word_q[15:8];
        end
        W2: begin
          im_addr  <= wbase + ADDR_W'(2);
          im_wdata <= word_q[23:16];
        end
        W3: begin
          im_addr  <= wbase + ADDR_W'(3);
          im_wdata <= word_q[31:24];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a 10-bit instance for normal loads and
// a 4-bit instance for capacity overflow / exact-fill.
module tb_imem_boot_loader;

  logic        clk;
  logic        rst_a, vld_a, lst_a, rdy_a, we_a, cr_a, done_a, err_a;
  logic [31:0] dat_a;
  logic [9:0]  addr_a;
  logic [7:0]  wd_a;
  logic [8:0]  wc_a;
  logic        rst_b, vld_b, lst_b, rdy_b, we_b, cr_b, done_b, err_b;
  logic [31:0] dat_b;
  logic [3:0]  addr_b;
  logic [7:0]  wd_b;
  logic [2:0]  wc_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_a [1024];
  int         wn_a  [1024];
  logic [7:0] mem_b [16];
  int         wn_b  [16];

  logic [31:0] words [3];
  logic [7:0]  exp3  [12];
  int          acc_cyc [3];
  int          nacc;
  int          bad;
  bit          acc;
  logic [31:0] w;

  imem_boot_loader #(.ADDR_W(10), .BASE_ADDR(0), .RELEASE_DELAY(2)) dut_a (
    .clk(clk), .reset(rst_a), .ld_valid(vld_a), .ld_ready(rdy_a), .ld_data(dat_a),
    .ld_last(lst_a), .im_we(we_a), .im_addr(addr_a), .im_wdata(wd_a),
    .core_reset(cr_a), .done(done_a), .err(err_a), .word_count(wc_a));

  imem_boot_loader #(.ADDR_W(4), .BASE_ADDR(0), .RELEASE_DELAY(2)) dut_b (
    .clk(clk), .reset(rst_b), .ld_valid(vld_b), .ld_ready(rdy_b), .ld_data(dat_b),
    .ld_last(lst_b), .im_we(we_b), .im_addr(addr_b), .im_wdata(wd_b),
    .core_reset(cr_b), .done(done_b), .err(err_b), .word_count(wc_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record any write visible this cycle, then advance to 1 time unit after the next edge.
  task automatic tick();
    if (we_a === 1'b1) begin mem_a[addr_a] = wd_a; wn_a[addr_a]++; end
    if (we_b === 1'b1) begin mem_b[addr_b] = wd_b; wn_b[addr_b]++; end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [31:0] d, input logic l);
    if (sel) begin vld_b = v; dat_b = d; lst_b = l; end
    else     begin vld_a = v; dat_a = d; lst_a = l; end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 1024; i++) begin mem_a[i] = '0; wn_a[i] = 0; end
    for (int i = 0; i < 16; i++)   begin mem_b[i] = '0; wn_b[i] = 0; end
  endtask

  task automatic do_reset(input bit sel);
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    tick();
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    tick();
  endtask

  // Offer a word and return once it is accepted (state W0) or the budget expires.
  task automatic send(input bit sel, input logic [31:0] d, input logic l, output bit ok);
    ok = 1'b0;
    drive(sel, 1'b1, d, l);
    for (int i = 0; i < 30 && !ok; i++) begin
      if ((sel ? rdy_b : rdy_a) === 1'b1) ok = 1'b1;
      tick();
    end
    drive(sel, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_done(input bit sel, input string tag);
    for (int i = 0; i < 40 && (sel ? done_b : done_a) !== 1'b1; i++) tick();
    chk(tag, {31'd0, sel ? done_b : done_a}, 32'd1);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    words = '{32'h00500093, 32'h00300113, 32'h002081B3};
    exp3  = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00,
              8'hB3, 8'h81, 8'h20, 8'h00};
    clear_models();
    tick(); tick();

    // Reset state
    chk("rst_ready", {31'd0, rdy_a}, 0);
    chk("rst_we", {31'd0, we_a}, 0);
    chk("rst_addr", {22'd0, addr_a}, 0);
    chk("rst_wdata", {24'd0, wd_a}, 0);
    chk("rst_core_reset", {31'd0, cr_a}, 1);
    chk("rst_done", {31'd0, done_a}, 0);
    chk("rst_err", {31'd0, err_a}, 0);
    chk("rst_wcount", {23'd0, wc_a}, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    chk("load_ready", {31'd0, rdy_a}, 1);

    // Single word with last: byte writes and exact release timing
    send(0, 32'h00500093, 1'b1, acc);
    chk("single_acc", {31'd0, acc}, 1);
    chk("w0_we", {31'd0, we_a}, 1);
    chk("w0_addr", {22'd0, addr_a}, 0);
    chk("w0_data", {24'd0, wd_a}, 32'h93);
    chk("w0_ready", {31'd0, rdy_a}, 0);
    tick();
    chk("w1_addr", {22'd0, addr_a}, 1);
    chk("w1_data", {24'd0, wd_a}, 32'h00);
    tick();
    chk("w2_addr", {22'd0, addr_a}, 2);
    chk("w2_data", {24'd0, wd_a}, 32'h50);
    tick();
    chk("w3_addr", {22'd0, addr_a}, 3);
    chk("w3_data", {24'd0, wd_a}, 32'h00);
    tick();
    chk("settle1_we", {31'd0, we_a}, 0);
    chk("settle1_core_reset", {31'd0, cr_a}, 1);
    chk("settle1_wcount", {23'd0, wc_a}, 1);
    tick();
    chk("settle2_core_reset", {31'd0, cr_a}, 1);
    chk("settle2_done", {31'd0, done_a}, 0);
    tick();
    chk("run_core_reset", {31'd0, cr_a}, 0);
    chk("run_done", {31'd0, done_a}, 1);
    bad = 0;
    drive(0, 1'b1, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (rdy_a !== 1'b0 || we_a !== 1'b0) bad++;
      tick();
    end
    drive(0, 1'b0, '0, 1'b0);
    chk("run_ignores_valid", bad, 0);
    chk("run_wcount", {23'd0, wc_a}, 1);

    // Three words with valid held high: ready pulses every 5 cycles
    do_reset(0);
    clear_models();
    nacc = 0;
    drive(0, 1'b1, words[0], 1'b0);
    for (int i = 0; i < 60 && nacc < 3; i++) begin
      if (rdy_a === 1'b1) begin
        acc_cyc[nacc] = i;
        nacc++;
        tick();
        if (nacc < 3) drive(0, 1'b1, words[nacc], nacc == 2);
        else          drive(0, 1'b0, '0, 1'b0);
      end else begin
        tick();
      end
    end
    drive(0, 1'b0, '0, 1'b0);
    chk("held_accepts", nacc, 3);
    chk("held_gap01", acc_cyc[1] - acc_cyc[0], 5);
    chk("held_gap12", acc_cyc[2] - acc_cyc[1], 5);
    wait_done(0, "held_done");
    chk("held_wcount", {23'd0, wc_a}, 3);
    bad = 0;
    for (int i = 0; i < 12; i++) if (mem_a[i] !== exp3[i] || wn_a[i] != 1) bad++;
    chk("held_mem_bad_bytes", bad, 0);

    // Same image with 7-cycle gaps between words
    do_reset(0);
    clear_models();
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      send(0, words[k], k == 2, acc);
      chk("gap_acc", {31'd0, acc}, 1);
      if (k < 2) begin
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 7; i++) begin
          if (we_a !== 1'b0 || rdy_a !== 1'b1) bad++;
          tick();
        end
      end
    end
    chk("gap_idle_bad_cycles", bad, 0);
    wait_done(0, "gap_done");
    bad = 0;
    for (int i = 0; i < 12; i++) if (mem_a[i] !== exp3[i] || wn_a[i] != 1) bad++;
    chk("gap_mem_bad_bytes", bad, 0);

    // Reset wins over a handshake in the same cycle
    do_reset(0);
    rst_a = 1'b1;
    drive(0, 1'b1, 32'hCAFEF00D, 1'b0);
    tick();
    rst_a = 1'b0;
    drive(0, 1'b0, '0, 1'b0);
    chk("rst_prio_we", {31'd0, we_a}, 0);
    tick();

    // Reset during W2 of the second word, then reload
    send(0, 32'h11223344, 1'b0, acc);
    for (int i = 0; i < 4; i++) tick();
    send(0, 32'hAABBCCDD, 1'b0, acc);
    tick();
    tick();
    chk("midw2_addr", {22'd0, addr_a}, 6);
    chk("midw2_data", {24'd0, wd_a}, 32'hBB);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("mid_rst_wcount", {23'd0, wc_a}, 0);
    chk("mid_rst_we", {31'd0, we_a}, 0);
    chk("mid_rst_core_reset", {31'd0, cr_a}, 1);
    chk("mid_rst_ready", {31'd0, rdy_a}, 0);
    clear_models();
    tick();
    send(0, 32'h11223344, 1'b0, acc);
    for (int i = 0; i < 4; i++) tick();
    send(0, 32'h55667788, 1'b1, acc);
    wait_done(0, "reload_done");
    chk("reload_wcount", {23'd0, wc_a}, 2);
    chk("reload_core_reset", {31'd0, cr_a}, 0);
    chk("reload_b0", {24'd0, mem_a[0]}, 32'h44);
    chk("reload_b3", {24'd0, mem_a[3]}, 32'h11);
    chk("reload_b4", {24'd0, mem_a[4]}, 32'h88);
    chk("reload_b6", {24'd0, mem_a[6]}, 32'h66);
    chk("reload_b7", {24'd0, mem_a[7]}, 32'h55);

    // ADDR_W=4: overflow after 4 words with no last
    do_reset(1);
    clear_models();
    for (int i = 0; i < 4; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      send(1, w, 1'b0, acc);
      chk("ovf_acc", {31'd0, acc}, 1);
      for (int j = 0; j < 4; j++) tick();
    end
    chk("ovf_err", {31'd0, err_b}, 1);
    chk("ovf_ready", {31'd0, rdy_b}, 0);
    chk("ovf_core_reset", {31'd0, cr_b}, 1);
    chk("ovf_done", {31'd0, done_b}, 0);
    chk("ovf_wcount", {29'd0, wc_b}, 4);
    send(1, 32'hFFFFFFFF, 1'b0, acc);
    chk("ovf_fifth_rejected", {31'd0, acc}, 0);
    chk("ovf_err_sticky", {31'd0, err_b}, 1);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem_b[i] !== 8'(i) || wn_b[i] != 1) bad++;
    chk("ovf_mem_bad_bytes", bad, 0);

    // ADDR_W=4: exact fill with last on the 4th word
    do_reset(1);
    clear_models();
    for (int i = 0; i < 4; i++) begin
      send(1, 32'h01020304 + 32'(i), i == 3, acc);
      if (i < 3) for (int j = 0; j < 4; j++) tick();
    end
    wait_done(1, "fill_done");
    chk("fill_err", {31'd0, err_b}, 0);
    chk("fill_core_reset", {31'd0, cr_b}, 0);
    chk("fill_wcount", {29'd0, wc_b}, 4);
    chk("fill_last_byte", {24'd0, mem_b[12]}, 32'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
